// File: rtl/comparator_pkg.sv
// Shared types for the comparator array: operation encoding and the S1 stage record.
// Stage fields are held at CmpMaxWidth; narrower operands are sign/zero-extended into them.
package comparator_pkg;

  localparam int CmpMaxWidth = 64;

  typedef enum logic [2:0] {
    CMP_INF       = 3'd0,
    CMP_SUP       = 3'd1,
    CMP_INF_OR_EQ = 3'd2,
    CMP_SUP_OR_EQ = 3'd3,
    CMP_EQ        = 3'd4,
    CMP_NEQ       = 3'd5
  } comparator_intr_e;

  typedef struct packed {
    comparator_intr_e       instr;
    logic                   is_signed;
    logic [CmpMaxWidth-1:0] op_b;
    logic [CmpMaxWidth-1:0] lo;
    logic [CmpMaxWidth-1:0] hi;
  } cmp_s1_t;

endpackage

// File: rtl/comparator_lane.sv
// One channel of the comparator array: purely combinational, zero latency, no flow control.
// Ordering ops compare op_a against op_b; eq/neq test op_a against the saturated [lo, hi] band.
module comparator_lane
  import comparator_pkg::*;
(
  input  logic [CmpMaxWidth-1:0] op_a,
  input  logic [CmpMaxWidth-1:0] op_b,
  input  logic [CmpMaxWidth-1:0] lo,
  input  logic [CmpMaxWidth-1:0] hi,
  input  comparator_intr_e       instr,
  input  logic                   is_signed,
  output logic                   result
);

  logic lt;
  logic gt;
  logic in_band;

  always_comb begin
    lt      = is_signed ? ($signed(op_a) < $signed(op_b)) : (op_a < op_b);
    gt      = is_signed ? ($signed(op_a) > $signed(op_b)) : (op_a > op_b);
    in_band = is_signed ? (($signed(lo) <= $signed(op_a)) && ($signed(op_a) <= $signed(hi)))
                        : ((lo <= op_a) && (op_a <= hi));
    result  = 1'b0;
    case (instr)
      CMP_INF:       result = lt;
      CMP_SUP:       result = gt;
      CMP_INF_OR_EQ: result = !gt;
      CMP_SUP_OR_EQ: result = !lt;
      CMP_EQ:        result = in_band;
      CMP_NEQ:       result = !in_band;
      default:       result = 1'b0;
    endcase
  end

endmodule

// File: rtl/comparator_array.sv
// N-lane comparator with tolerance band and per-lane debounce; 2-cycle latency, valid/ready on both sides,
// a stalled output holds both stages. Signed operation is built only with COMPARATOR_SIGNED_EN defined.
module comparator_array
  import comparator_pkg::*;
#(
  parameter int DataWidth     = 32,
  parameter int NumChannels   = 4,
  parameter int DebounceDepth = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  in_valid_i,
  output logic                                  in_ready_o,
  input  comparator_intr_e                      instr_i,
  input  logic [NumChannels-1:0][DataWidth-1:0] op_a_i,
  input  logic [DataWidth-1:0]                  op_b_i,
  input  logic [DataWidth-1:0]                  op_precision_i,
`ifdef COMPARATOR_SIGNED_EN
  input  logic                                  op_signed_i,
`endif
  input  logic                                  clear_i,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic [NumChannels-1:0]                result_o,
  output logic                                  any_o,
  output logic                                  all_o,
  output logic [NumChannels-1:0]                stable_o
);

  localparam int ExtW = DataWidth + 2;
  localparam int CntW = $clog2(DebounceDepth + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceDepth);

  function automatic logic [CmpMaxWidth-1:0] widen(input logic [DataWidth-1:0] v, input logic sgn);
    logic [CmpMaxWidth-1:0] r;
    r = {CmpMaxWidth{sgn & v[DataWidth-1]}};
    r[DataWidth-1:0] = v;
    return r;
  endfunction

  logic in_sgn;
`ifdef COMPARATOR_SIGNED_EN
  assign in_sgn = op_signed_i;
`else
  assign in_sgn = 1'b0;
`endif

  // Two guard bits keep b +/- precision exact before clamping, for both signednesses.
  logic [ExtW-1:0]      b_x;
  logic [ExtW-1:0]      p_x;
  logic [ExtW-1:0]      lo_x;
  logic [ExtW-1:0]      hi_x;
  logic [ExtW-1:0]      min_x;
  logic [ExtW-1:0]      max_x;
  logic [DataWidth-1:0] lo_sat;
  logic [DataWidth-1:0] hi_sat;

  always_comb begin
    b_x    = {{2{in_sgn & op_b_i[DataWidth-1]}}, op_b_i};
    p_x    = {2'b00, op_precision_i};
    lo_x   = b_x - p_x;
    hi_x   = b_x + p_x;
    min_x  = in_sgn ? {3'b111, {(DataWidth-1){1'b0}}} : '0;
    max_x  = in_sgn ? {3'b000, {(DataWidth-1){1'b1}}} : {2'b00, {DataWidth{1'b1}}};
    lo_sat = ($signed(lo_x) < $signed(min_x)) ? min_x[DataWidth-1:0] : lo_x[DataWidth-1:0];
    hi_sat = ($signed(hi_x) > $signed(max_x)) ? max_x[DataWidth-1:0] : hi_x[DataWidth-1:0];
  end

  cmp_s1_t                s1_q;
  logic [CmpMaxWidth-1:0] s1_op_a [NumChannels];
  logic                   s1_vld;
  logic                   s2_vld;
  logic                   s2_take;
  logic                   accept;
  logic                   out_hs;
  logic [NumChannels-1:0] lane_res;

  assign s2_take     = !s2_vld || out_ready_i;
  assign in_ready_o  = !s1_vld || s2_take;
  assign accept      = in_valid_i && in_ready_o;
  assign out_hs      = s2_vld && out_ready_i;
  assign out_valid_o = s2_vld;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_vld <= 1'b0;
      s1_q   <= '0;
      for (int i = 0; i < NumChannels; i++) begin
        s1_op_a[i] <= '0;
      end
    end else if (accept) begin
      s1_vld         <= 1'b1;
      s1_q.instr     <= instr_i;
      s1_q.is_signed <= in_sgn;
      s1_q.op_b      <= widen(op_b_i, in_sgn);
      s1_q.lo        <= widen(lo_sat, in_sgn);
      s1_q.hi        <= widen(hi_sat, in_sgn);
      for (int i = 0; i < NumChannels; i++) begin
        s1_op_a[i] <= widen(op_a_i[i], in_sgn);
      end
    end else if (s2_take) begin
      s1_vld <= 1'b0;
    end
  end

  for (genvar g = 0; g < NumChannels; g++) begin : g_lane
    comparator_lane u_lane (
      .op_a      (s1_op_a[g]),
      .op_b      (s1_q.op_b),
      .lo        (s1_q.lo),
      .hi        (s1_q.hi),
      .instr     (s1_q.instr),
      .is_signed (s1_q.is_signed),
      .result    (lane_res[g])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_vld   <= 1'b0;
      result_o <= '0;
    end else if (s2_take) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        result_o <= lane_res;
      end
    end
  end

  assign any_o = |result_o;
  assign all_o = &result_o;

  // Debounce history advances only on delivered results; clear takes priority.
  logic [CntW-1:0]        cnt_q [NumChannels];
  logic [NumChannels-1:0] prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= '0;
      for (int i = 0; i < NumChannels; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (clear_i) begin
      prev_q <= '0;
      for (int i = 0; i < NumChannels; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (out_hs) begin
      prev_q <= result_o;
      for (int i = 0; i < NumChannels; i++) begin
        if (result_o[i] == prev_q[i]) begin
          if (cnt_q[i] != CntMax) begin
            cnt_q[i] <= cnt_q[i] + CntW'(1);
          end
        end else begin
          cnt_q[i] <= CntW'(1);
        end
      end
    end
  end

  always_comb begin
    stable_o = '0;
    for (int i = 0; i < NumChannels; i++) begin
      stable_o[i] = (cnt_q[i] == CntMax);
    end
  end

endmodule
